// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor: drives PLL reset/power-down, qualifies the
// asynchronous lock, and releases the downstream reset only after stable lock.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned RETRY_MAX        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       pll_pwd,
  output logic       sys_rst,
  output logic       locked_ok,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MAX_A   = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_STABLE_CYC) ? MAX_A : LOCK_STABLE_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned RW      = $clog2(RETRY_MAX + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt, retry_inc;
  logic [7:0]    loss_nxt;
  logic          lock_s1, lock_s;

  assign state = st;

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    loss_nxt  = lock_loss_cnt;
    retry_inc = retry_cnt + RW'(1);
    if (relock_req) begin
      st_nxt    = ST_RESET;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (st)
        ST_RESET: begin
          if (cnt == RST_LAST) begin
            st_nxt  = ST_WAIT_LOCK;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            st_nxt  = ST_STABLE;
            cnt_nxt = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nxt = retry_inc;
            st_nxt    = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            st_nxt  = ST_WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STABLE_LAST) begin
            st_nxt    = ST_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            st_nxt    = ST_RESET;
            cnt_nxt   = '0;
            retry_nxt = '0;
            if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
          end
        end
        ST_FAULT: cnt_nxt = '0;
        default: begin
          st_nxt  = ST_RESET;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are flops aligned with st.
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= ST_RESET;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      lock_s1       <= 1'b0;
      lock_s        <= 1'b0;
      pll_rst       <= 1'b1;
      pll_pwd       <= 1'b0;
      sys_rst       <= 1'b1;
      locked_ok     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      lock_s1       <= pll_lock;
      lock_s        <= lock_s1;
      st            <= st_nxt;
      cnt           <= cnt_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      pll_rst       <= (st_nxt == ST_RESET) || (st_nxt == ST_FAULT);
      pll_pwd       <= (st_nxt == ST_FAULT);
      sys_rst       <= (st_nxt != ST_RUN);
      locked_ok     <= (st_nxt == ST_RUN);
      fault         <= (st_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed timelines plus a randomized run
// against a dwell-time reference model.
module tb_pll_lock_supervisor;
  localparam int unsigned RP = 4;
  localparam int unsigned TO = 100;
  localparam int unsigned SC = 8;
  localparam int unsigned RM = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, pll_pwd, sys_rst, locked_ok, fault;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;
  logic [15:0] obs;

  int checks = 0;
  int failures = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC(RP),
    .LOCK_TIMEOUT_CYC(TO),
    .LOCK_STABLE_CYC(SC),
    .RETRY_MAX(RM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock(pll_lock),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .pll_pwd(pll_pwd),
    .sys_rst(sys_rst),
    .locked_ok(locked_ok),
    .fault(fault),
    .state(state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {state, pll_rst, pll_pwd, sys_rst, locked_ok, fault, lock_loss_cnt};

  // Expected output vector from a phase number and a loss count.
  function automatic logic [15:0] spec_vec(input int s, input int loss);
    logic [2:0] s3;
    logic [7:0] l8;
    s3 = 3'(s);
    l8 = 8'(loss);
    return {s3, (s == 0) || (s == 4), (s == 4), (s != 3), (s == 3), (s == 4), l8};
  endfunction

  // Reference model: phase plus edges elapsed since the phase was entered.
  int cyc = 0;
  int m_state = 0, m_entry = 0, m_retry = 0, m_loss = 0;
  bit hist[$] = '{1'b0, 1'b0};

  always @(posedge clk) begin : model
    bit lk;
    int dwell;
    cyc++;
    dwell = cyc - m_entry;
    if (rst) begin
      m_state = 0; m_entry = cyc; m_retry = 0; m_loss = 0;
      hist = '{1'b0, 1'b0};
    end else begin
      lk = hist[1];
      hist.push_front(pll_lock);
      void'(hist.pop_back());
      if (relock_req) begin
        m_state = 0; m_entry = cyc; m_retry = 0;
      end else begin
        case (m_state)
          0: if (dwell == RP) begin m_state = 1; m_entry = cyc; end
          1: if (lk) begin m_state = 2; m_entry = cyc; end
             else if (dwell == TO) begin
               m_retry++;
               m_state = (m_retry == RM) ? 4 : 0;
               m_entry = cyc;
             end
          2: if (!lk) begin m_state = 1; m_entry = cyc; end
             else if (dwell == SC) begin m_state = 3; m_entry = cyc; m_retry = 0; end
          3: if (!lk) begin
               m_state = 0; m_entry = cyc; m_retry = 0;
               if (m_loss < 255) m_loss++;
             end
          default: ;
        endcase
      end
    end
  end

  // rst held for n edges; returns at the negedge after the last rst edge (edge 0).
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; relock_req = 1'b0; pll_lock = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; pll_lock = 1'b1; relock_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== spec_vec(0, 0)) begin
      failures++;
      $display("FAIL reset got=%h want=%h", obs, spec_vec(0, 0));
    end
    relock_req = 1'b0; pll_lock = 1'b0; rst = 1'b0;
  endtask

  task automatic test_bringup();
    int es;
    do_reset(3);
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      es = (e < 4) ? 0 : (e < 22) ? 1 : (e < 30) ? 2 : 3;
      checks++;
      if (obs !== spec_vec(es, 0)) begin
        failures++;
        $display("FAIL bringup edge=%0d got=%h want=%h", e, obs, spec_vec(es, 0));
      end
      if (e == 19) pll_lock = 1'b1;
    end
  endtask

  task automatic test_stable_glitch();
    int es;
    do_reset(3);
    for (int e = 1; e <= 38; e++) begin
      @(negedge clk);
      es = (e < 4) ? 0 : (e < 22) ? 1 : (e < 27) ? 2 : (e < 28) ? 1 : (e < 36) ? 2 : 3;
      checks++;
      if (obs !== spec_vec(es, 0)) begin
        failures++;
        $display("FAIL stable_glitch edge=%0d got=%h want=%h", e, obs, spec_vec(es, 0));
      end
      if (e == 19) pll_lock = 1'b1;
      if (e == 24) pll_lock = 1'b0;
      if (e == 25) pll_lock = 1'b1;
    end
  endtask

  task automatic test_timeout_fault();
    int es;
    do_reset(2);
    for (int e = 1; e <= 216; e++) begin
      @(negedge clk);
      es = (e < 4) ? 0 : (e < 104) ? 1 : (e < 108) ? 0 : (e < 208) ? 1 :
           (e < 211) ? 4 : (e < 215) ? 0 : 1;
      checks++;
      if (obs !== spec_vec(es, 0)) begin
        failures++;
        $display("FAIL timeout_fault edge=%0d got=%h want=%h", e, obs, spec_vec(es, 0));
      end
      relock_req = (e == 210);
    end
    relock_req = 1'b0;
  endtask

  // relock_req lands on the edge where the second timeout would enter FAULT.
  task automatic test_relock_priority();
    int es;
    do_reset(2);
    for (int e = 1; e <= 315; e++) begin
      @(negedge clk);
      es = (e < 4) ? 0 : (e < 104) ? 1 : (e < 108) ? 0 : (e < 208) ? 1 :
           (e < 212) ? 0 : (e < 312) ? 1 : 0;
      checks++;
      if (obs !== spec_vec(es, 0)) begin
        failures++;
        $display("FAIL relock_priority edge=%0d got=%h want=%h", e, obs, spec_vec(es, 0));
      end
      relock_req = (e == 207);
    end
    relock_req = 1'b0;
  endtask

  // One timeout before lock, then loss in RUN: a single later timeout must not fault.
  task automatic test_lock_loss();
    int es, el;
    do_reset(2);
    for (int e = 1; e <= 268; e++) begin
      @(negedge clk);
      es = (e < 4) ? 0 : (e < 104) ? 1 : (e < 108) ? 0 : (e < 122) ? 1 :
           (e < 130) ? 2 : (e < 142) ? 3 : (e < 146) ? 0 : (e < 246) ? 1 :
           (e < 250) ? 0 : (e < 258) ? 1 : (e < 266) ? 2 : 3;
      el = (e >= 142) ? 1 : 0;
      checks++;
      if (obs !== spec_vec(es, el)) begin
        failures++;
        $display("FAIL lock_loss edge=%0d got=%h want=%h", e, obs, spec_vec(es, el));
      end
      if (e == 119) pll_lock = 1'b1;
      if (e == 139) pll_lock = 1'b0;
      if (e == 255) pll_lock = 1'b1;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      for (int c = 0; c < 20; c++) begin
        pll_lock = (c >= 2);
        @(negedge clk);
        checks++;
        if (obs !== spec_vec(m_state, m_loss)) begin
          failures++;
          $display("FAIL saturation iter=%0d got=%h want=%h", i, obs, spec_vec(m_state, m_loss));
        end
      end
    end
    checks++;
    if (obs !== spec_vec(3, 255)) begin
      failures++;
      $display("FAIL saturation_final got=%h want=%h", obs, spec_vec(3, 255));
    end
  endtask

  task automatic test_rst_mid_run();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== spec_vec(0, 0)) begin
      failures++;
      $display("FAIL rst_mid_run got=%h want=%h", obs, spec_vec(0, 0));
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int seg = 0;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        pll_lock = ~pll_lock;
        if (pll_lock) seg = $urandom_range(60, 1);
        else if ($urandom_range(7, 0) == 0) seg = $urandom_range(260, 100);
        else seg = $urandom_range(40, 1);
      end
      seg--;
      relock_req = ($urandom_range(199, 0) == 0);
      rst = ($urandom_range(999, 0) == 0);
      @(negedge clk);
      checks++;
      if (obs !== spec_vec(m_state, m_loss)) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, obs, spec_vec(m_state, m_loss));
      end
    end
    relock_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_stable_glitch();
    test_timeout_fault();
    test_relock_priority();
    test_lock_loss();
    test_saturation();
    test_rst_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
